// File: rtl/led_click_ctrlmod_pkg.sv
// Shared definitions for the click-driven LED running-light.
//   TIMER_W        : width of the auto-step timer
//   TRIG_*         : bit positions inside the 2-bit click-pulse bus
//   modeT          : HOLD / RUN mode encoding
//   DIR_LEFT/RIGHT : rotation direction encoding
//   T_STEP_DEFAULT : auto-step period in clocks (500 ms @ 50 MHz)
package led_click_ctrlmod_pkg;

    localparam int unsigned TIMER_W     = 28;
    localparam int unsigned TRIG_W      = 2;
    localparam int unsigned TRIG_SCLICK = 1;
    localparam int unsigned TRIG_DCLICK = 0;

    typedef enum logic {
        MODE_HOLD = 1'b0,
        MODE_RUN  = 1'b1
    } modeT;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam logic [TIMER_W-1:0] T_STEP_DEFAULT = 28'd25_000_000;

endpackage

// File: rtl/led_click_ctrlmod_step_timer.sv
// Free-running period timer for the RUN-mode auto-step.
//   CLOCK : system clock
//   RESET : synchronous active-high reset
//   en    : count while high, held at 0 while low
//   clr   : force count back to 0 this edge
//   done  : high while count sits at T-1 and the timer is enabled
//           (count wraps to 0 on the following edge, so this is a 1-cycle pulse)
module led_click_ctrlmod_step_timer
    import led_click_ctrlmod_pkg::*;
#(
    parameter logic [TIMER_W-1:0] T = T_STEP_DEFAULT
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic en,
    input  logic clr,
    output logic done
);

    logic [TIMER_W-1:0] count;
    logic               atEnd;

    assign atEnd = (count == (T - TIMER_W'(1)));
    assign done  = en && atEnd;

    // Count 0..T-1, self-clearing at the terminal count.
    always_ff @(posedge CLOCK) begin
        if (RESET || clr || !en) begin
            count <= '0;
        end else if (atEnd) begin
            count <= '0;
        end else begin
            count <= count + TIMER_W'(1);
        end
    end

endmodule

// File: rtl/led_click_ctrlmod.sv
// One-hot LED running-light driven by single/double click pulses.
//   CLOCK : system clock, all state on rising edge
//   RESET : synchronous active-high reset
//   iTrig : [1] single-click pulse, [0] double-click pulse (1 cycle each)
//   oLED  : one-hot LED drive, bit0 = LED0
//   oMode : 0 = HOLD (manual step), 1 = RUN (auto step every T_STEP clocks)
//   oDir  : 0 = step left (i -> i+1), 1 = step right (i -> i-1)
//   oStep : 1-cycle pulse in the cycle oLED takes a new value
module led_click_ctrlmod
    import led_click_ctrlmod_pkg::*;
#(
    parameter int unsigned        LED_N  = 4,
    parameter logic [TIMER_W-1:0] T_STEP = T_STEP_DEFAULT
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [TRIG_W-1:0] iTrig,
    output logic [LED_N-1:0]  oLED,
    output logic              oMode,
    output logic              oDir,
    output logic              oStep
);

    modeT             state;
    logic             sClick;
    logic             dClick;
    logic             tmrEn;
    logic             tmrClr;
    logic             tmrDone;
    logic [LED_N-1:0] ledRot;

    assign sClick = iTrig[TRIG_SCLICK];
    assign dClick = iTrig[TRIG_DCLICK];

    // Any click restarts the RUN period; in HOLD the timer is parked at 0.
    assign tmrEn  = (state == MODE_RUN);
    assign tmrClr = sClick || dClick;

    // One-position wrap-around rotation in the current direction.
    assign ledRot = (oDir == DIR_LEFT) ? {oLED[LED_N-2:0], oLED[LED_N-1]}
                                       : {oLED[0], oLED[LED_N-1:1]};

    assign oMode = (state == MODE_RUN);

    led_click_ctrlmod_step_timer #(
        .T     (T_STEP)
    ) uStepTimer (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .en    (tmrEn),
        .clr   (tmrClr),
        .done  (tmrDone)
    );

    // Mode FSM plus LED/direction registers; double > single > timer expiry.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state <= MODE_HOLD;
            oLED  <= LED_N'(1);
            oDir  <= DIR_LEFT;
            oStep <= 1'b0;
        end else begin
            oStep <= 1'b0;
            case (state)
                MODE_HOLD: begin
                    if (dClick) begin
                        state <= MODE_RUN;
                    end else if (sClick) begin
                        oLED  <= ledRot;
                        oStep <= 1'b1;
                    end
                end
                MODE_RUN: begin
                    if (dClick) begin
                        state <= MODE_HOLD;
                    end else if (sClick) begin
                        oDir <= ~oDir;
                    end else if (tmrDone) begin
                        oLED  <= ledRot;
                        oStep <= 1'b1;
                    end
                end
                default: begin
                    state <= MODE_HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_click_ctrlmod.sv
// Bench for led_click_ctrlmod: directed scenarios followed by random clicks,
// every cycle compared against an index/counter model of the running-light.
module tb_led_click_ctrlmod;

    localparam int unsigned N = 4;
    localparam int unsigned T = 8;

    logic         CLOCK = 1'b0;
    logic         RESET;
    logic [1:0]   iTrig;
    logic [N-1:0] oLED;
    logic         oMode;
    logic         oDir;
    logic         oStep;

    int nAssert = 0;
    int nFail   = 0;

    // Model state: lit LED index, mode, direction, cycles elapsed in the RUN period.
    int mIdx     = 0;
    int mRun     = 0;
    int mDir     = 0;
    int mElapsed = 0;
    int mStep    = 0;

    led_click_ctrlmod #(
        .LED_N  (N),
        .T_STEP (28'(T))
    ) dut (
        .CLOCK  (CLOCK),
        .RESET  (RESET),
        .iTrig  (iTrig),
        .oLED   (oLED),
        .oMode  (oMode),
        .oDir   (oDir),
        .oStep  (oStep)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rotateModel();
        if (mDir != 0) mIdx = (mIdx + int'(N) - 1) % int'(N);
        else           mIdx = (mIdx + 1) % int'(N);
        mStep = 1;
    endtask

    // Effect of one clock edge with the given inputs.
    task automatic modelEdge(input logic [1:0] trig, input logic rst);
        mStep = 0;
        if (rst) begin
            mIdx = 0; mRun = 0; mDir = 0; mElapsed = 0;
        end else if (mRun == 0) begin
            if (trig[0]) begin
                mRun = 1; mElapsed = 0;
            end else if (trig[1]) begin
                rotateModel();
            end
        end else begin
            if (trig[0]) begin
                mRun = 0; mElapsed = 0;
            end else if (trig[1]) begin
                mDir = 1 - mDir; mElapsed = 0;
            end else if (mElapsed == int'(T) - 1) begin
                rotateModel(); mElapsed = 0;
            end else begin
                mElapsed++;
            end
        end
    endtask

    // Drive inputs, take one edge, then compare all outputs 1 time unit later.
    task automatic tick(input logic [1:0] trig, input logic rst);
        iTrig = trig;
        RESET = rst;
        @(posedge CLOCK);
        modelEdge(trig, rst);
        #1;
        check("oLED",  32'(oLED),  32'(1) << mIdx);
        check("oMode", 32'(oMode), 32'(mRun));
        check("oDir",  32'(oDir),  32'(mDir));
        check("oStep", 32'(oStep), 32'(mStep));
    endtask

    initial begin
        logic [N-1:0] frozen;
        int           r;
        logic [1:0]   trig;

        iTrig = 2'b00;
        RESET = 1'b1;

        // Reset, then idle.
        tick(2'b00, 1'b1);
        tick(2'b00, 1'b1);
        check("reset_oLED",  32'(oLED),  32'h1);
        check("reset_oMode", 32'(oMode), 32'h0);
        repeat (20) tick(2'b00, 1'b0);
        check("idle_oLED", 32'(oLED), 32'h1);

        // HOLD: four single clicks walk the ring and wrap.
        for (int k = 0; k < 4; k++) begin
            tick(2'b10, 1'b0);
            check("hold_single_step", 32'(oStep), 32'h1);
            tick(2'b00, 1'b0);
            tick(2'b00, 1'b0);
        end
        check("hold_wrap_oLED", 32'(oLED), 32'h1);

        // Double click -> RUN, auto steps every T cycles.
        tick(2'b01, 1'b0);
        check("run_entry_mode", 32'(oMode), 32'h1);
        repeat (T) tick(2'b00, 1'b0);
        check("run_step1_oLED", 32'(oLED), 32'h2);
        repeat (T) tick(2'b00, 1'b0);
        check("run_step2_oLED", 32'(oLED), 32'h4);

        // Single click on the expiry cycle: no step, direction flips.
        for (int k = 0; k < int'(T) && mElapsed != int'(T) - 1; k++) tick(2'b00, 1'b0);
        tick(2'b10, 1'b0);
        check("expiry_click_no_step", 32'(oStep), 32'h0);
        check("expiry_click_dir",     32'(oDir),  32'h1);
        check("expiry_click_oLED",    32'(oLED),  32'h4);
        for (int k = 0; k < 4 * int'(T) && mIdx != 0; k++) tick(2'b00, 1'b0);
        for (int k = 0; k <= int'(T) && mIdx == 0; k++) tick(2'b00, 1'b0);
        check("right_wrap_oLED", 32'(oLED), 32'h8);

        // Double in RUN -> HOLD, then 2'b11 in HOLD acts as double.
        tick(2'b01, 1'b0);
        check("run_to_hold_mode", 32'(oMode), 32'h0);
        frozen = oLED;
        tick(2'b11, 1'b0);
        check("both_bits_mode", 32'(oMode), 32'h1);
        check("both_bits_oLED", 32'(oLED),  32'(frozen));
        repeat (3) tick(2'b00, 1'b0);
        tick(2'b01, 1'b0);
        frozen = oLED;
        repeat (30) tick(2'b00, 1'b0);
        check("hold_frozen_oLED", 32'(oLED), 32'(frozen));

        // Reset mid-RUN with LED at 0100 and timer at 5.
        for (int k = 0; k < int'(N) && mIdx != 2; k++) begin
            tick(2'b10, 1'b0);
            tick(2'b00, 1'b0);
        end
        tick(2'b01, 1'b0);
        repeat (5) tick(2'b00, 1'b0);
        check("pre_reset_oLED", 32'(oLED), 32'h4);
        tick(2'b00, 1'b1);
        check("mid_reset_oLED",  32'(oLED),  32'h1);
        check("mid_reset_oMode", 32'(oMode), 32'h0);
        check("mid_reset_oDir",  32'(oDir),  32'h0);
        repeat (2 * T) tick(2'b00, 1'b0);
        check("post_reset_no_step", 32'(oLED), 32'h1);

        // Random clicks with occasional reset.
        for (int k = 0; k < 600; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 85)      trig = 2'b00;
            else if (r < 92) trig = 2'b10;
            else if (r < 97) trig = 2'b01;
            else             trig = 2'b11;
            tick(trig, $urandom_range(0, 199) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
